// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Stage-1 instruction fetch of the pipelined RISC core. Owns the program
//   counter and issues one-outstanding requests to instruction memory. Every
//   cycle it presents {PCOut, IROut, BBOut} to the stage-1/2 pipeline buffer;
//   BBOut=1 marks a bubble (the buffer then loads opcode 0).
//
//   Optional feature macro: FETCH_PERF_EN
//     defined   -> adds FetchCount / BubbleCount performance counters
//     undefined -> counters and their ports are absent
//
// Ports
//   clk           in   1     single clock, rising edge
//   rst_n         in   1     asynchronous, active-low reset
//   Stall         in   1     decode cannot accept an instruction this cycle
//   BranchTaken   in   1     redirect request from a later stage
//   BranchTarget  in   PC_W  redirect address, sampled when BranchTaken=1
//   ImemReq       out  1     request valid; held until ImemValid
//   ImemAddr      out  PC_W  request address (always the fetch PC)
//   ImemRdata     in   OP_W  opcode; valid only when ImemValid=1
//   ImemValid     in   1     response for ImemAddr
//   PCOut         out  PC_W  (fetch address + 1) of presented instruction
//   IROut         out  OP_W  presented opcode
//   BBOut         out  1     1 = bubble / no valid instruction
//   FetchCount    out  32    (FETCH_PERF_EN) cycles loading BBOut=0
//   BubbleCount   out  32    (FETCH_PERF_EN) cycles loading BBOut=1
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter int              OP_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    output logic            ImemReq,
    output logic [PC_W-1:0] ImemAddr,
    input  logic [OP_W-1:0] ImemRdata,
    input  logic            ImemValid,
    output logic [PC_W-1:0] PCOut,
    output logic [OP_W-1:0] IROut,
    output logic            BBOut
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     FetchCount,
    output logic [31:0]     BubbleCount
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] w_fetch_pc_nxt;
    logic [PC_W-1:0] w_fetch_pc_inc;
    logic [PC_W-1:0] r_redir;
    logic [PC_W-1:0] w_redir_nxt;
    logic [PC_W-1:0] r_hold_pc;
    logic [PC_W-1:0] w_hold_pc_nxt;
    logic [OP_W-1:0] r_hold_ir;
    logic [OP_W-1:0] w_hold_ir_nxt;

    logic [PC_W-1:0] r_pc_p1;
    logic [OP_W-1:0] r_ir_p1;
    logic            r_bb_p1;
    logic [PC_W-1:0] w_pc_nxt;
    logic [OP_W-1:0] w_ir_nxt;
    logic            w_bb_nxt;

    // Wraps naturally modulo 2^PC_W.
    assign w_fetch_pc_inc = r_fetch_pc + PC_W'(1);

    assign ImemAddr = r_fetch_pc;
    assign ImemReq  = (r_state == S_WAIT) || (r_state == S_DRAIN);

    assign PCOut = r_pc_p1;
    assign IROut = r_ir_p1;
    assign BBOut = r_bb_p1;

    // Next-state and next-output logic. Every path defaults to a bubble, so
    // only the cases that deliver an instruction override the output triple.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_redir_nxt    = r_redir;
        w_hold_pc_nxt  = r_hold_pc;
        w_hold_ir_nxt  = r_hold_ir;
        w_pc_nxt       = w_fetch_pc_inc;
        w_ir_nxt       = '0;
        w_bb_nxt       = 1'b1;

        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (ImemValid) begin
                    if (BranchTaken) begin
                        // Redirect wins over stall: the returned opcode is dropped.
                        w_fetch_pc_nxt = BranchTarget;
                    end else if (Stall) begin
                        w_hold_pc_nxt  = w_fetch_pc_inc;
                        w_hold_ir_nxt  = ImemRdata;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                        w_state_nxt    = S_HOLD;
                    end else begin
                        w_pc_nxt       = w_fetch_pc_inc;
                        w_ir_nxt       = ImemRdata;
                        w_bb_nxt       = 1'b0;
                        w_fetch_pc_nxt = w_fetch_pc_inc;
                    end
                end else if (BranchTaken) begin
                    // A request is in flight and must not be retracted; remember
                    // the target and throw the response away when it arrives.
                    w_redir_nxt = BranchTarget;
                    w_state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (BranchTaken) begin
                    w_redir_nxt = BranchTarget;
                end
                if (ImemValid) begin
                    w_fetch_pc_nxt = BranchTaken ? BranchTarget : r_redir;
                    w_state_nxt    = S_WAIT;
                end
            end

            S_HOLD: begin
                if (BranchTaken) begin
                    w_fetch_pc_nxt = BranchTarget;
                    w_state_nxt    = S_WAIT;
                end else if (!Stall) begin
                    w_pc_nxt    = r_hold_pc;
                    w_ir_nxt    = r_hold_ir;
                    w_bb_nxt    = 1'b0;
                    w_state_nxt = S_WAIT;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_redir    <= '0;
            r_hold_pc  <= '0;
            r_hold_ir  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_redir    <= w_redir_nxt;
            r_hold_pc  <= w_hold_pc_nxt;
            r_hold_ir  <= w_hold_ir_nxt;
        end
    end

    // ---- stage 1 -> stage 1/2 buffer boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_p1 <= '0;
            r_ir_p1 <= '0;
            r_bb_p1 <= 1'b1;
        end else begin
            r_pc_p1 <= w_pc_nxt;
            r_ir_p1 <= w_ir_nxt;
            r_bb_p1 <= w_bb_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Counters track the value being loaded into BBOut, so they advance in
    // the same edge as the presented output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (w_bb_nxt) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
        end
    end

    assign FetchCount  = r_fetch_cnt;
    assign BubbleCount = r_bubble_cnt;
`endif

endmodule
